jtframe_dipbank: RTL and testbench

JTFRAME_DIPBANK -- requirements
Module: jtframe_dipbank

---
 rtl/jtframe_dipbank_if.sv | 18 +
 rtl/jtframe_dipbank.sv | 134 +++++++++++++
 tb/tb_jtframe_dipbank.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/jtframe_dipbank_if.sv
// DIP download bus: load window plus ioctl byte strobe.
// The master drives it and the DIP bank consumes it.
interface jtframe_dipbank_if;
  logic       dip_load;
  logic       ioctl_wr;
  logic [2:0] ioctl_addr;
  logic [7:0] ioctl_dout;

  modport master (
    output dip_load, ioctl_wr,
    output ioctl_addr, ioctl_dout
  );

  modport slave (
    input dip_load, ioctl_wr,
    input ioctl_addr, ioctl_dout
  );
endinterface

// File: rtl/jtframe_dipbank.sv
// Shadowed DIP banks committed on vblank, with optional game-reset pulse.
// Define JTFRAME_DIPBANK_RSTREQ_EN to enable RSTHOLD and rst_req.
module jtframe_dipbank #(
  parameter int                 BANKS   = 3,
  parameter logic [8*BANKS-1:0] DEFAULT = {BANKS{8'hFF}},
  parameter logic [BANKS-1:0]   RSTMASK = {BANKS{1'b0}},
  parameter int                 HOLD    = 16
)(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [31:0]        status,
  input  logic               game_pause,
  input  logic               vb,
  jtframe_dipbank_if.slave   ioctl,
  output logic [8*BANKS-1:0] dipsw,
  output logic               dip_chg,
  output logic               rst_req,
  output logic               dip_pause,
  output logic               dip_flip,
  output logic               dip_test
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_COMMIT = 3'd3;
  localparam logic [2:0] S_RST    = 3'd4;

  logic [2:0]         r_state;
  logic [8*BANKS-1:0] r_shadow;
  logic [8*BANKS-1:0] r_dipsw;
  logic               r_vb;
  logic               r_chg;
  logic               r_rst;
  logic [7:0]         r_cnt;
  logic               r_pause;
  logic               r_flip;
  logic               r_test;

  logic               w_wr;
  logic               w_vbrise;
  logic               w_rsthit;
  logic [BANKS-1:0]   w_chg;
  logic               w_unused;

  assign w_wr = ioctl.ioctl_wr & ioctl.dip_load
              & ({1'b0, ioctl.ioctl_addr} < 4'(BANKS));
  assign w_vbrise = vb & ~r_vb;

  always_comb begin
    w_chg = '0;
    for (int b = 0; b < BANKS; b++)
      w_chg[b] = |(r_dipsw[8*b +: 8] ^ r_shadow[8*b +: 8]);
  end

`ifdef JTFRAME_DIPBANK_RSTREQ_EN
  assign w_rsthit = |(w_chg & RSTMASK);
  assign rst_req  = r_rst;
  assign w_unused = ^{status[31:13], status[11],
                      status[9:2], status[0]};
`else
  assign w_rsthit = 1'b0;
  assign rst_req  = 1'b0;
  assign w_unused = ^{status[31:13], status[11],
                      status[9:2], status[0],
                      RSTMASK, r_rst, w_chg};
`endif

  assign dipsw     = r_dipsw;
  assign dip_chg   = r_chg;
  assign dip_pause = r_pause;
  assign dip_flip  = r_flip;
  assign dip_test  = r_test;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_shadow <= DEFAULT;
      r_dipsw  <= DEFAULT;
      r_vb     <= 1'b0;
      r_chg    <= 1'b0;
      r_rst    <= 1'b0;
      r_cnt    <= 8'd0;
    end else begin
      r_vb  <= vb;
      r_chg <= (r_state == S_COMMIT);
      for (int b = 0; b < BANKS; b++)
        if (w_wr && ioctl.ioctl_addr == 3'(b))
          r_shadow[8*b +: 8] <= ioctl.ioctl_dout;
      unique case (r_state)
        S_IDLE:
          if (ioctl.dip_load) r_state <= S_LOAD;
        S_LOAD:
          if (!ioctl.dip_load) r_state <= S_WAIT;
        S_WAIT:
          if (ioctl.dip_load) r_state <= S_LOAD;
          else if (w_vbrise)  r_state <= S_COMMIT;
        S_COMMIT: begin
          r_dipsw <= r_shadow;
          if (w_rsthit) begin
            r_state <= S_RST;
            r_rst   <= 1'b1;
            r_cnt   <= 8'(HOLD - 1);
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RST:
          if (r_cnt == 8'd0) begin
            r_rst   <= 1'b0;
            r_state <= ioctl.dip_load ? S_LOAD : S_IDLE;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        default:
          r_state <= S_IDLE;
      endcase
    end
  end

  // Control DIPs track the OSD every cycle, regardless of the FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pause <= 1'b1;
      r_flip  <= 1'b1;
      r_test  <= 1'b1;
    end else begin
      r_pause <= ~(game_pause | status[12]);
      r_flip  <= ~status[1];
      r_test  <= ~status[10];
    end
  end

endmodule

// File: tb/tb_jtframe_dipbank.sv
// Randomized bench for jtframe_dipbank against a transaction-level model.
// Follows JTFRAME_DIPBANK_RSTREQ_EN to pick the rst_req expectation.
module tb_jtframe_dipbank;

  localparam int         BANKS = 3;
  localparam int         HOLD  = 16;
  localparam logic [2:0] MASK  = 3'b010;
`ifdef JTFRAME_DIPBANK_RSTREQ_EN
  localparam bit RST_EN = 1'b1;
`else
  localparam bit RST_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] status = '0;
  logic        game_pause = 1'b0;
  logic        vb = 1'b0;
  logic [23:0] dipsw;
  logic        dip_chg, rst_req;
  logic        dip_pause, dip_flip, dip_test;

  jtframe_dipbank_if bus();

  jtframe_dipbank #(
    .BANKS   (BANKS),
    .DEFAULT (24'hFFFFFF),
    .RSTMASK (MASK),
    .HOLD    (HOLD)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .status     (status),
    .game_pause (game_pause),
    .vb         (vb),
    .ioctl      (bus),
    .dipsw      (dipsw),
    .dip_chg    (dip_chg),
    .rst_req    (rst_req),
    .dip_pause  (dip_pause),
    .dip_flip   (dip_flip),
    .dip_test   (dip_test)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int chg_n = 0;
  int rsthi = 0;

  logic [7:0] shadow [BANKS];
  logic [7:0] commit_m [BANKS];

  always @(negedge clk) begin
    if (dip_chg) chg_n++;
    if (rst_req) rsthi++;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] packc();
    return {commit_m[2], commit_m[1], commit_m[0]};
  endfunction

  task automatic model_reset();
    for (int b = 0; b < BANKS; b++) begin
      shadow[b]   = 8'hFF;
      commit_m[b] = 8'hFF;
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    bus.ioctl_addr = a;
    bus.ioctl_dout = d;
    bus.ioctl_wr   = 1'b1;
    tick();
    bus.ioctl_wr   = 1'b0;
    if (bus.dip_load && a < 3'(BANKS)) shadow[a] = d;
  endtask

  task automatic load_begin();
    bus.dip_load = 1'b1;
    tick();
  endtask

  task automatic commit(input bit vb_hi, input string tag);
    int         c0, r0, exp_rst;
    logic [2:0] chg;
    c0 = chg_n;
    r0 = rsthi;
    vb = vb_hi;
    tick();
    bus.dip_load = 1'b0;
    tick(4);
    check({tag, ":hold"}, dipsw, packc());
    check({tag, ":early"}, chg_n - c0, 0);
    vb = 1'b0;
    tick(2);
    vb = 1'b1;
    tick(HOLD + 8);
    vb = 1'b0;
    tick(2);
    for (int b = 0; b < BANKS; b++)
      chg[b] = (shadow[b] != commit_m[b]);
    exp_rst = (RST_EN && |(chg & MASK)) ? HOLD : 0;
    commit_m = shadow;
    check({tag, ":dipsw"}, dipsw, packc());
    check({tag, ":chg"}, chg_n - c0, 1);
    check({tag, ":rst"}, rsthi - r0, exp_rst);
  endtask

  initial begin
    int c0;
    bus.dip_load   = 1'b0;
    bus.ioctl_wr   = 1'b0;
    bus.ioctl_addr = '0;
    bus.ioctl_dout = '0;
    model_reset();

    status = 32'h0000_1402;
    game_pause = 1'b1;
    tick(2);
    check("rst:dipsw", dipsw, 24'hFFFFFF);
    check("rst:chg", dip_chg, 0);
    check("rst:req", rst_req, 0);
    check("rst:ctl", {dip_pause, dip_flip, dip_test}, 3'b111);
    status = '0;
    game_pause = 1'b0;
    rst_n = 1'b1;
    tick(2);

    load_begin();
    wr(3'd3, 8'h00);
    commit(1'b0, "oob");
    check("oob:val", dipsw, 24'hFFFFFF);

    load_begin();
    wr(3'd0, 8'h5A);
    wr(3'd2, 8'h0F);
    commit(1'b0, "basic");
    check("basic:val", dipsw, 24'h0FFF5A);

    load_begin();
    wr(3'd1, 8'h33);
    commit(1'b1, "vbhi");

    load_begin();
    wr(3'd0, 8'hA5);
    commit(1'b0, "b0only");

    load_begin();
    wr(3'd2, 8'h44);
    bus.dip_load = 1'b0;
    tick(3);
    check("reload:hold", dipsw, packc());
    bus.dip_load = 1'b1;
    tick();
    wr(3'd1, 8'h77);
    commit(1'b0, "reload");

    for (int i = 0; i < 20; i++) begin
      wr(3'($urandom_range(0, 7)), 8'($urandom));
      load_begin();
      repeat ($urandom_range(1, 6)) begin
        if ($urandom_range(0, 3) == 0)
          wr(3'($urandom_range(0, 2)), commit_m[$urandom_range(0, 2)]);
        else
          wr(3'($urandom_range(0, 7)), 8'($urandom));
      end
      commit(1'($urandom_range(0, 1)), "rnd");
    end

    load_begin();
    wr(3'd1, ~commit_m[1]);
    bus.dip_load = 1'b0;
    tick(2);
    vb = 1'b1;
    tick(4);
    check("rsthold:req", rst_req, RST_EN);
    rst_n = 1'b0;
    #1;
    check("rsthold:req0", rst_req, 0);
    check("rsthold:dipsw", dipsw, 24'hFFFFFF);
    check("rsthold:chg", dip_chg, 0);
    vb = 1'b0;
    tick(2);
    rst_n = 1'b1;
    model_reset();
    c0 = chg_n;
    tick(3);
    vb = 1'b1;
    tick(4);
    vb = 1'b0;
    check("rsthold:idle", chg_n - c0, 0);
    check("rsthold:after", dipsw, 24'hFFFFFF);

    load_begin();
    wr(3'd0, 8'h12);
    rst_n = 1'b0;
    tick();
    bus.dip_load = 1'b0;
    rst_n = 1'b1;
    model_reset();
    c0 = chg_n;
    tick(2);
    vb = 1'b1;
    tick(4);
    vb = 1'b0;
    tick();
    check("rstload:chg", chg_n - c0, 0);
    check("rstload:dipsw", dipsw, 24'hFFFFFF);

    load_begin();
    wr(3'd2, 8'hC3);
    commit(1'b0, "postrst");

    status = 32'h0000_1000;
    game_pause = 1'b0;
    tick();
    check("osd:pause", dip_pause, 0);
    status = 32'h0000_0002;
    tick();
    check("osd:flip", dip_flip, 0);
    check("osd:unpause", dip_pause, 1);

    for (int i = 0; i < 16; i++) begin
      logic [31:0] s;
      logic        g;
      s = $urandom;
      g = 1'($urandom_range(0, 1));
      status = s;
      game_pause = g;
      tick();
      check("osd:rnd", {dip_pause, dip_flip, dip_test},
            {~(g | s[12]), ~s[1], ~s[10]});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
